// File: rtl/dram_responder_if.sv
// Purpose : request/response bundle between the bus arbiter's DRAM group and the responder.
// Latency : wires only, no state.
// Backpres: busy flows slave->master; the master holds its request until busy drops.
//
// Signals (master = arbiter side, slave = memory side):
//   w_dram_addr  [31:0]  byte address of request
//   w_dram_wdata [31:0]  right-aligned store data
//   w_dram_we_t          store toggle (each level change is one store)
//   w_dram_le            one-cycle load strobe
//   w_dram_ctrl  [2:0]   funct3 width/sign control
//   w_dram_odata [31:0]  formatted load result
//   w_dram_busy          request detected or in service
//   w_dram_err           sticky error flag
interface dram_responder_if;
    logic [31:0] w_dram_addr;
    logic [31:0] w_dram_wdata;
    logic        w_dram_we_t;
    logic        w_dram_le;
    logic [2:0]  w_dram_ctrl;
    logic [31:0] w_dram_odata;
    logic        w_dram_busy;
    logic        w_dram_err;

    modport master (
        output w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        input  w_dram_odata, w_dram_busy, w_dram_err
    );

    modport slave (
        input  w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl,
        output w_dram_odata, w_dram_busy, w_dram_err
    );
endinterface

// File: rtl/dram_responder.sv
// Purpose : DRAM-port responder; serves toggle-encoded stores and strobed loads from a byte-enable RAM.
// Latency : load LAT+3 cycles (odata valid from T+LAT+3), store LAT+2 cycles (RAM written at end of T+LAT+1).
// Backpres: combinational busy, high in the request cycle and throughout service; one request at a time.
//
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   bus       dram_responder_if.slave (address/data/toggle/strobe in, odata/busy/err out)
// Parameters: BASE (first byte address), AW (word-address width), LAT (wait cycles, 0..255).
// Optional feature: define DRAM_RESP_ERR_EN to flag and drop out-of-range or misaligned requests;
// without it w_dram_err is 0, addresses wrap modulo capacity and misaligned low bits are ignored.
module dram_responder #(
    parameter logic [31:0] BASE = 32'h8000_0000,
    parameter int          AW   = 12,
    parameter int          LAT  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    dram_responder_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        RD   = 3'd2,
        FMT  = 3'd3,
        WR   = 3'd4
    } state_t;

    localparam logic [7:0] LAT_M1 = (LAT > 0) ? 8'(LAT - 1) : 8'd0;
    localparam int         DEPTH  = 1 << AW;

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t      state_q,   state_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [2:0]  ctrl_q,    ctrl_d;
    logic        op_st_q,   op_st_d;    // 1: latched request is a store
    logic        bad_q,     bad_d;      // latched request is dropped
    logic        we_seen_q, we_seen_d;  // last accepted store-toggle level
    logic        ld_pend_q, ld_pend_d;  // load deferred behind a same-cycle store
    logic [31:0] odata_q,   odata_d;
    logic        err_q,     err_d;

    logic        st_req;
    logic        ld_req;
    logic        bad_in;

    // RAM side
    logic [31:0] mem [DEPTH];
    logic [31:0] ram_rdata_q;
    logic [AW-1:0] ram_idx;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdat;
    logic        ram_we;
    logic        ram_re;

    assign st_req = (bus.w_dram_we_t != we_seen_q);
    assign ld_req = bus.w_dram_le | ld_pend_q;

`ifdef DRAM_RESP_ERR_EN
    // Out of range uses the wrapped 32-bit offset; alignment only matters for H and W.
    always_comb begin
        bad_in = 1'b0;
        if ((bus.w_dram_addr - BASE) >= (32'd4 << AW)) begin
            bad_in = 1'b1;
        end
        case (bus.w_dram_ctrl[1:0])
            2'b01:   if (bus.w_dram_addr[0])          bad_in = 1'b1;
            2'b10:   if (bus.w_dram_addr[1:0] != 2'b00) bad_in = 1'b1;
            default: ;
        endcase
    end
`else
    assign bad_in = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Process 1: state register (plus datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            ctrl_q    <= 3'd0;
            op_st_q   <= 1'b0;
            bad_q     <= 1'b0;
            // Adopt the current toggle level so reset never fabricates a store.
            we_seen_q <= bus.w_dram_we_t;
            ld_pend_q <= 1'b0;
            odata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ctrl_q    <= ctrl_d;
            op_st_q   <= op_st_d;
            bad_q     <= bad_d;
            we_seen_q <= we_seen_d;
            ld_pend_q <= ld_pend_d;
            odata_q   <= odata_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (st_req) begin
                    state_d = (LAT == 0) ? WR : WAIT;
                end else if (ld_req) begin
                    state_d = (LAT == 0) ? RD : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_M1) begin
                    state_d = op_st_q ? WR : RD;
                end
            end
            RD:      state_d = FMT;
            FMT:     state_d = IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs and datapath
    // ------------------------------------------------------------------
    function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                             input logic [1:0]  lo,
                                             input logic [2:0]  f);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f[1:0])
            2'b00:   r = f[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        cnt_d     = 8'd0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ctrl_d    = ctrl_q;
        op_st_d   = op_st_q;
        bad_d     = bad_q;
        we_seen_d = we_seen_q;
        ld_pend_d = ld_pend_q;
        odata_d   = odata_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (st_req) begin
                    addr_d    = bus.w_dram_addr;
                    wdata_d   = bus.w_dram_wdata;
                    ctrl_d    = bus.w_dram_ctrl;
                    op_st_d   = 1'b1;
                    bad_d     = bad_in;
                    err_d     = err_q | bad_in;
                    we_seen_d = bus.w_dram_we_t;
                    // Store wins the tie; remember the load for the next IDLE.
                    if (bus.w_dram_le) begin
                        ld_pend_d = 1'b1;
                    end
                end else if (ld_req) begin
                    addr_d    = bus.w_dram_addr;
                    ctrl_d    = bus.w_dram_ctrl;
                    op_st_d   = 1'b0;
                    bad_d     = bad_in;
                    err_d     = err_q | bad_in;
                    ld_pend_d = 1'b0;
                end
            end
            WAIT: begin
                cnt_d = (cnt_q == LAT_M1) ? 8'd0 : cnt_q + 8'd1;
            end
            FMT: begin
                odata_d = bad_q ? 32'd0 : fmt_load(ram_rdata_q, addr_q[1:0], ctrl_q);
            end
            default: ;
        endcase
    end

    // Lane selection and replication for stores.
    always_comb begin
        ram_be   = 4'b1111;
        ram_wdat = wdata_q;
        case (ctrl_q[1:0])
            2'b00: begin
                ram_be   = 4'b0001 << addr_q[1:0];
                ram_wdat = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                ram_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                ram_wdat = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Word index wraps modulo capacity; an asserted reset in the WR cycle aborts the write.
    assign ram_idx = AW'((addr_q - BASE) >> 2);
    assign ram_we  = (state_q == WR) && !bad_q && !RST;
    assign ram_re  = (state_q == RD);

    // RAM contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[ram_idx][8*i +: 8] <= ram_wdat[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_idx];
        end
    end

    assign bus.w_dram_odata = odata_q;
    assign bus.w_dram_busy  = (state_q != IDLE) || st_req || ld_req;
    assign bus.w_dram_err   = err_q;

endmodule
